// File: rtl/time_gen.sv
// Alarm-clock timebase. Divides clk into a 1 Hz strobe (one_sec) and a 1/60 Hz strobe (one_min).
// fast_watch makes one_min fire on every one_sec strobe for demonstration.
module time_gen #(
    parameter int CLK_PER_SEC = 256,
    parameter int SEC_PER_MIN = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic reset_count,
    input  logic fast_watch,
    output logic one_min,
    output logic one_sec
);

    localparam int CNT_W = $clog2(CLK_PER_SEC);
    localparam int SEC_W = $clog2(SEC_PER_MIN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);

    logic [CNT_W-1:0] cnt;
    logic [SEC_W-1:0] sec;
    logic             cnt_term;
    logic             sec_term;

    assign cnt_term = (cnt == CNT_LAST);
    assign sec_term = (sec == SEC_LAST);

    // NOTE: non-blocking assignments so every update on this edge sees the pre-edge cnt/sec.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            sec     <= '0;
            one_sec <= 1'b0;
            one_min <= 1'b0;
        end else if (reset_count) begin
            cnt     <= '0;
            sec     <= '0;
            one_sec <= 1'b0;
            one_min <= 1'b0;
        end else begin
            cnt     <= cnt_term ? '0 : cnt + 1'b1;
            one_sec <= cnt_term;
            // fast_watch only matters on the terminal-count edge, so mid-second toggles cannot glitch.
            one_min <= cnt_term && (fast_watch || sec_term);
            if (cnt_term) begin
                sec <= sec_term ? '0 : sec + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_time_gen.sv
// Bench for time_gen: directed scenarios plus randomized mode/clear traffic,
// checked every cycle against an edge-count arithmetic model.
module tb_time_gen;

    localparam int CPS = 256;
    localparam int SPM = 60;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset_count = 1'b0;
    logic fast_watch = 1'b0;
    logic one_min;
    logic one_sec;

    int   total = 0;
    int   bad = 0;
    int   edges = 0;          // edges counted since last release of reset/reset_count
    logic exp_sec = 1'b0;
    logic exp_min = 1'b0;
    int   sec_cnt = 0;
    int   min_cnt = 0;
    int   last_min_edge = -1;

    time_gen #(
        .CLK_PER_SEC(CPS),
        .SEC_PER_MIN(SPM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reset_count(reset_count),
        .fast_watch (fast_watch),
        .one_min    (one_min),
        .one_sec    (one_sec)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock edge: inputs are captured before the edge, outputs checked 1 time unit after.
    task automatic step();
        logic r;
        logic rc;
        logic fw;
        r  = reset;
        rc = reset_count;
        fw = fast_watch;
        @(posedge clk);
        #1;
        if (!r || rc) begin
            edges   = 0;
            exp_sec = 1'b0;
            exp_min = 1'b0;
        end else begin
            edges++;
            exp_sec = (edges % CPS == 0);
            exp_min = exp_sec && (fw || ((edges / CPS) % SPM == 0));
        end
        check("one_sec", int'(one_sec), int'(exp_sec));
        check("one_min", int'(one_min), int'(exp_min));
        if (one_sec) sec_cnt++;
        if (one_min) begin
            min_cnt++;
            last_min_edge = edges;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset hold across many edges
        #2;
        check("reset_sec_t0", int'(one_sec), 0);
        check("reset_min_t0", int'(one_min), 0);
        run(1000);

        // Release between edges, then three 1 Hz ticks
        reset   = 1'b1;
        sec_cnt = 0;
        min_cnt = 0;
        run(3 * CPS);
        check("three_ticks", sec_cnt, 3);
        check("no_min_in_3s", min_cnt, 0);

        // First and second minute in normal mode
        run(SPM * CPS - 3 * CPS);
        check("min1_count", min_cnt, 1);
        check("min1_edge", last_min_edge, SPM * CPS);
        check("min1_level", int'(one_min), 1);
        run(SPM * CPS);
        check("min2_count", min_cnt, 2);
        check("min2_edge", last_min_edge, 2 * SPM * CPS);

        // Fast mode for 10 ticks, then back to normal at sec=10
        fast_watch  = 1'b1;
        reset_count = 1'b1;
        step();
        reset_count = 1'b0;
        sec_cnt = 0;
        min_cnt = 0;
        run(10 * CPS);
        check("fast_min_count", min_cnt, 10);
        check("fast_sec_count", sec_cnt, 10);
        fast_watch = 1'b0;
        min_cnt = 0;
        run((SPM - 10) * CPS);
        check("back_normal_count", min_cnt, 1);
        check("back_normal_edge", last_min_edge, SPM * CPS);

        // reset_count pulse at cnt=200 with sec away from zero
        run(5 * CPS);
        for (int i = 0; i < CPS && (edges % CPS) != 200; i++) step();
        check("rc_at_cnt200", edges % CPS, 200);
        reset_count = 1'b1;
        step();
        reset_count = 1'b0;
        sec_cnt = 0;
        min_cnt = 0;
        run(CPS - 1);
        check("rc_no_early_tick", sec_cnt, 0);
        step();
        check("rc_first_tick", int'(one_sec), 1);
        run((SPM - 1) * CPS);
        check("rc_sec_restart_min", min_cnt, 1);
        check("rc_sec_restart_lvl", int'(one_min), 1);

        // Async reset while both strobes are high (fast mode)
        fast_watch = 1'b1;
        for (int i = 0; i <= CPS && !exp_sec; i++) step();
        check("pre_async_sec", int'(one_sec), 1);
        check("pre_async_min", int'(one_min), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_drop_sec", int'(one_sec), 0);
        check("async_drop_min", int'(one_min), 0);
        edges   = 0;
        exp_sec = 1'b0;
        exp_min = 1'b0;
        run(3);
        reset      = 1'b1;
        fast_watch = 1'b0;
        sec_cnt = 0;
        run(CPS);
        check("async_restart_ticks", sec_cnt, 1);
        check("async_restart_lvl", int'(one_sec), 1);

        // Randomized mode toggles and clear pulses
        repeat (8000) begin
            if ($urandom_range(0, 299) == 0) fast_watch = ~fast_watch;
            reset_count = ($urandom_range(0, 1999) == 0);
            step();
        end
        reset_count = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
